// File: rtl/rate_param_decoder.sv
// ---------------------------------------------------------------------------
// rate_param_decoder
//
// Translates a rate code (802.11a RATE bits or 802.11n MCS) and a PSDU length
// into the parameters the demodulator, deinterleaver and decode-FSM symbol
// counter need. The outputs are a unified rate index, the modulation, the code
// rate, N_DBPS and the number of data OFDM symbols,
// N_SYM = ceil((8*length + 22) / N_DBPS).
// N_SYM comes from a restoring long divider that produces one quotient bit
// per cycle.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high reset
//   enable         clock enable; 0 freezes the FSM and all state
//   rate[7:0]      bit7=0: legacy, rate[3:0] = RATE bits R4..R1
//                  bit7=1: HT, rate[6:0] = MCS
//   length         PSDU length in bytes
//   input_strobe   request pulse
//   busy           high from the cycle after acceptance through the
//                  output_strobe cycle
//   idx            unified rate index (legacy 0..7, HT HT_IDX_OFFSET+MCS)
//   modulation     0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM
//   code_rate      0 1/2, 1 2/3, 2 3/4, 3 5/6
//   n_dbps         data bits per OFDM symbol
//   n_sym          number of data OFDM symbols
//   is_ht          result belongs to an HT rate
//   invalid        rate code is unsupported
//   output_strobe  one-cycle result-valid pulse
//   drop_strobe    one-cycle pulse after a request was ignored while busy
// ---------------------------------------------------------------------------
module rate_param_decoder #(
    parameter int LEN_WIDTH     = 16,
    parameter int HT_IDX_OFFSET = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           rate,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic                 input_strobe,
    output logic                 busy,
    output logic [7:0]           idx,
    output logic [1:0]           modulation,
    output logic [1:0]           code_rate,
    output logic [8:0]           n_dbps,
    output logic [LEN_WIDTH-1:0] n_sym,
    output logic                 is_ht,
    output logic                 invalid,
    output logic                 output_strobe,
    output logic                 drop_strobe
);

    // The dividend 8*length+22 fits in LEN_WIDTH+4 bits without overflow.
    localparam int DIV_W = LEN_WIDTH + 4;
    localparam int CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DIVIDE,
        DONE
    } state_t;

    state_t state, state_next;

    // Request captured at acceptance.
    logic [7:0]           rate_q;
    logic [LEN_WIDTH-1:0] length_q;

    // Table entry registered in LOOKUP, used by DIVIDE.
    logic [7:0] w_idx;
    logic [1:0] w_mod;
    logic [1:0] w_cr;
    logic [8:0] w_dbps;

    // Divider working state: rq starts as the dividend and the quotient bits
    // shift in from the bottom as the dividend bits leave from the top.
    logic [DIV_W-1:0] rq;
    logic [8:0]       rem_q;
    logic [CNT_W-1:0] cnt;
    logic             drop_q;

    // -----------------------------------------------------------------------
    // Rate table lookup (combinational on the latched rate code)
    // -----------------------------------------------------------------------
    logic       lk_valid;
    logic [7:0] lk_idx;
    logic [1:0] lk_mod;
    logic [1:0] lk_cr;
    logic [8:0] lk_dbps;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        lk_valid = 1'b0;
        lk_idx   = 8'd0;
        lk_mod   = 2'd0;
        lk_cr    = 2'd0;
        lk_dbps  = 9'd0;
        if (!rate_q[7]) begin
            // Legacy: R4 must be set; R1..R3 select the entry.
            lk_valid = rate_q[3];
            case (rate_q[2:0])
                3'b011: begin lk_idx = 8'd0; lk_mod = 2'd0; lk_cr = 2'd0; lk_dbps = 9'd24;  end
                3'b111: begin lk_idx = 8'd1; lk_mod = 2'd0; lk_cr = 2'd2; lk_dbps = 9'd36;  end
                3'b010: begin lk_idx = 8'd2; lk_mod = 2'd1; lk_cr = 2'd0; lk_dbps = 9'd48;  end
                3'b110: begin lk_idx = 8'd3; lk_mod = 2'd1; lk_cr = 2'd2; lk_dbps = 9'd72;  end
                3'b001: begin lk_idx = 8'd4; lk_mod = 2'd2; lk_cr = 2'd0; lk_dbps = 9'd96;  end
                3'b101: begin lk_idx = 8'd5; lk_mod = 2'd2; lk_cr = 2'd2; lk_dbps = 9'd144; end
                3'b000: begin lk_idx = 8'd6; lk_mod = 2'd3; lk_cr = 2'd1; lk_dbps = 9'd192; end
                default: begin lk_idx = 8'd7; lk_mod = 2'd3; lk_cr = 2'd2; lk_dbps = 9'd216; end
            endcase
        end else begin
            // HT: only single-stream MCS 0..7 are supported.
            lk_valid = (rate_q[6:3] == 4'd0);
            lk_idx   = 8'(HT_IDX_OFFSET) + {5'd0, rate_q[2:0]};
            case (rate_q[2:0])
                3'd0:    begin lk_mod = 2'd0; lk_cr = 2'd0; lk_dbps = 9'd26;  end
                3'd1:    begin lk_mod = 2'd1; lk_cr = 2'd0; lk_dbps = 9'd52;  end
                3'd2:    begin lk_mod = 2'd1; lk_cr = 2'd2; lk_dbps = 9'd78;  end
                3'd3:    begin lk_mod = 2'd2; lk_cr = 2'd0; lk_dbps = 9'd104; end
                3'd4:    begin lk_mod = 2'd2; lk_cr = 2'd2; lk_dbps = 9'd156; end
                3'd5:    begin lk_mod = 2'd3; lk_cr = 2'd1; lk_dbps = 9'd208; end
                3'd6:    begin lk_mod = 2'd3; lk_cr = 2'd2; lk_dbps = 9'd234; end
                default: begin lk_mod = 2'd3; lk_cr = 2'd3; lk_dbps = 9'd260; end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // One restoring-division step
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0]     dividend;
    logic [9:0]           trial;
    logic                 fits;
    logic [8:0]           rem_step;
    logic [DIV_W-1:0]     q_step;
    logic [LEN_WIDTH-1:0] n_sym_final;
    logic                 last_div;

    assign dividend = DIV_W'({length_q, 3'b000}) + DIV_W'(22);
    assign trial    = {rem_q, rq[DIV_W-1]};
    assign fits     = (trial >= {1'b0, w_dbps});
    // The remainder stays below the divisor (at most 260), so 9 bits hold it
    // whether or not the subtraction happens.
    assign rem_step = fits ? 9'(trial - {1'b0, w_dbps}) : trial[8:0];
    assign q_step   = {rq[DIV_W-2:0], fits};
    // Round the quotient up when there is a remainder. With n_dbps >= 24 the
    // result always fits in LEN_WIDTH bits.
    assign n_sym_final = q_step[LEN_WIDTH-1:0] + LEN_WIDTH'(rem_step != 9'd0);
    assign last_div    = (cnt == CNT_W'(DIV_W - 1));

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples values from before the edge, regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                IDLE:    if (input_strobe) state_next = LOOKUP;
                LOOKUP:  state_next = lk_valid ? DIVIDE : DONE;
                DIVIDE:  if (last_div) state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rate_q     <= '0;
            length_q   <= '0;
            w_idx      <= '0;
            w_mod      <= '0;
            w_cr       <= '0;
            w_dbps     <= '0;
            rq         <= '0;
            rem_q      <= '0;
            cnt        <= '0;
            drop_q     <= 1'b0;
            idx        <= '0;
            modulation <= '0;
            code_rate  <= '0;
            n_dbps     <= '0;
            n_sym      <= '0;
            is_ht      <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            // A request that arrives while a decode is in flight, including
            // its DONE cycle, is reported on the next cycle.
            drop_q <= enable && input_strobe && (state != IDLE);
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (input_strobe) begin
                            rate_q   <= rate;
                            length_q <= length;
                        end
                    end
                    LOOKUP: begin
                        w_idx  <= lk_idx;
                        w_mod  <= lk_mod;
                        w_cr   <= lk_cr;
                        w_dbps <= lk_dbps;
                        rq     <= dividend;
                        rem_q  <= '0;
                        cnt    <= '0;
                        if (!lk_valid) begin
                            // Unsupported code: report it in the next cycle,
                            // echoing the raw code as the index.
                            idx        <= {1'b0, rate_q[6:0]};
                            modulation <= 2'd0;
                            code_rate  <= 2'd0;
                            n_dbps     <= 9'd0;
                            n_sym      <= '0;
                            is_ht      <= rate_q[7];
                            invalid    <= 1'b1;
                        end
                    end
                    DIVIDE: begin
                        rq    <= q_step;
                        rem_q <= rem_step;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_div) begin
                            idx        <= w_idx;
                            modulation <= w_mod;
                            code_rate  <= w_cr;
                            n_dbps     <= w_dbps;
                            n_sym      <= n_sym_final;
                            is_ht      <= rate_q[7];
                            invalid    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy          = (state != IDLE);
    assign output_strobe = enable && (state == DONE);
    assign drop_strobe   = enable && drop_q;

endmodule

// File: tb/tb_rate_param_decoder.sv
// ---------------------------------------------------------------------------
// tb_rate_param_decoder
//
// Directed testbench for rate_param_decoder. Each vector carries
// hand-computed results. The bench drives inputs and samples outputs 1 ns
// after the rising edge. It counts latency from the acceptance cycle T.
// ---------------------------------------------------------------------------
module tb_rate_param_decoder;

    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    rate;
    logic [LW-1:0] length;
    logic          input_strobe;
    logic          busy;
    logic [7:0]    idx;
    logic [1:0]    modulation;
    logic [1:0]    code_rate;
    logic [8:0]    n_dbps;
    logic [LW-1:0] n_sym;
    logic          is_ht;
    logic          invalid;
    logic          output_strobe;
    logic          drop_strobe;

    int checks = 0;
    int errors = 0;

    rate_param_decoder #(.LEN_WIDTH(LW), .HT_IDX_OFFSET(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .rate          (rate),
        .length        (length),
        .input_strobe  (input_strobe),
        .busy          (busy),
        .idx           (idx),
        .modulation    (modulation),
        .code_rate     (code_rate),
        .n_dbps        (n_dbps),
        .n_sym         (n_sym),
        .is_ht         (is_ht),
        .invalid       (invalid),
        .output_strobe (output_strobe),
        .drop_strobe   (drop_strobe)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle; on return the bench observes T+1.
    task automatic issue(input logic [7:0] r, input logic [LW-1:0] l);
        rate         = r;
        length       = l;
        input_strobe = 1'b1;
        step();
        input_strobe = 1'b0;
    endtask

    // Advance until output_strobe; lat is the cycle offset from T and starts
    // at the offset already reached. It returns -1 on timeout.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!output_strobe && lat < 80) begin
            step();
            lat++;
        end
        if (!output_strobe) lat = -1;
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [7:0] e_idx, input logic [1:0] e_mod,
                                input logic [1:0] e_cr, input logic [8:0] e_dbps,
                                input logic [LW-1:0] e_nsym, input logic e_ht,
                                input logic e_inv);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".idx"}, idx, e_idx);
        check({tag, ".modulation"}, modulation, e_mod);
        check({tag, ".code_rate"}, code_rate, e_cr);
        check({tag, ".n_dbps"}, n_dbps, e_dbps);
        check({tag, ".n_sym"}, n_sym, e_nsym);
        check({tag, ".is_ht"}, is_ht, e_ht);
        check({tag, ".invalid"}, invalid, e_inv);
        check({tag, ".busy_done"}, busy, 1'b1);
    endtask

    initial begin
        int lat;
        int strobes;

        reset        = 1'b1;
        enable       = 1'b1;
        rate         = 8'd0;
        length       = '0;
        input_strobe = 1'b0;
        step();
        step();
        check("reset.busy", busy, 0);
        check("reset.idx", idx, 0);
        check("reset.n_dbps", n_dbps, 0);
        check("reset.n_sym", n_sym, 0);
        check("reset.strobes", {output_strobe, drop_strobe, invalid, is_ht}, 0);
        reset = 1'b0;
        step();

        // Legacy 6 Mb/s: 822/24 -> 35.
        issue(8'h0B, 16'd100);
        check("leg6.busy", busy, 1);
        wait_done(1, lat);
        check_result("leg6", lat, 22, 8'd0, 2'd0, 2'd0, 9'd24, 16'd35, 1'b0, 1'b0);
        step();
        check("leg6.busy_clear", busy, 0);
        check("leg6.strobe_once", output_strobe, 0);

        // Legacy 54 Mb/s: 12022/216 -> 56.
        issue(8'h0C, 16'd1500);
        wait_done(1, lat);
        check_result("leg54", lat, 22, 8'd7, 2'd3, 2'd2, 9'd216, 16'd56, 1'b0, 1'b0);
        step();

        // HT MCS7 at maximum length: 524302/260 -> 2017.
        issue(8'h87, 16'd65535);
        wait_done(1, lat);
        check_result("mcs7", lat, 22, 8'd15, 2'd3, 2'd3, 9'd260, 16'd2017, 1'b1, 1'b0);
        step();

        // HT MCS0 exact division: 78/26 = 3.
        issue(8'h80, 16'd7);
        wait_done(1, lat);
        check_result("mcs0", lat, 22, 8'd8, 2'd0, 2'd0, 9'd26, 16'd3, 1'b1, 1'b0);
        step();

        // Legacy with R4 clear: invalid, reported at T+2.
        issue(8'h03, 16'd100);
        wait_done(1, lat);
        check_result("inv_leg", lat, 2, 8'd3, 2'd0, 2'd0, 9'd0, 16'd0, 1'b0, 1'b1);
        step();

        // MCS 9: invalid HT.
        issue(8'h89, 16'd100);
        wait_done(1, lat);
        check_result("inv_ht", lat, 2, 8'd9, 2'd0, 2'd0, 9'd0, 16'd0, 1'b1, 1'b1);
        step();

        // Request with enable low is ignored without a drop pulse.
        enable       = 1'b0;
        input_strobe = 1'b1;
        step();
        step();
        input_strobe = 1'b0;
        enable       = 1'b1;
        check("dis_req.busy", busy, 0);
        check("dis_req.drop", drop_strobe, 0);
        step();
        check("dis_req.busy_after", busy, 0);

        // A second request at T+5 is dropped; the first result is unaffected.
        issue(8'h0B, 16'd100);
        for (int i = 0; i < 4; i++) step();
        rate         = 8'h87;
        length       = 16'd9;
        input_strobe = 1'b1;
        step();
        input_strobe = 1'b0;
        check("drop.pulse", drop_strobe, 1);
        step();
        check("drop.single", drop_strobe, 0);
        wait_done(7, lat);
        check_result("drop", lat, 22, 8'd0, 2'd0, 2'd0, 9'd24, 16'd35, 1'b0, 1'b0);
        step();

        // Four disabled cycles mid-divide delay the result by exactly four.
        issue(8'h0C, 16'd1500);
        for (int i = 0; i < 7; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("freeze.busy", busy, 1);
        enable = 1'b1;
        wait_done(12, lat);
        check_result("freeze", lat, 26, 8'd7, 2'd3, 2'd2, 9'd216, 16'd56, 1'b0, 1'b0);
        step();

        // Reset at T+10 aborts the divide and clears every output.
        issue(8'h87, 16'd65535);
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.idx", idx, 0);
        check("abort.n_sym", n_sym, 0);
        check("abort.n_dbps", n_dbps, 0);
        check("abort.flags", {output_strobe, drop_strobe, invalid, is_ht, modulation, code_rate}, 0);

        // A new request is accepted right after reset; no stray strobe appears.
        issue(8'h80, 16'd7);
        check("post_reset.busy", busy, 1);
        strobes = 0;
        lat = 1;
        while (lat < 30) begin
            if (output_strobe) begin
                strobes++;
                check("post_reset.latency", lat, 22);
                check("post_reset.n_sym", n_sym, 3);
            end
            step();
            lat++;
        end
        check("post_reset.strobe_count", strobes, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
